boot_imem: RTL and testbench

Parametrised, bootloader-fed instruction memory for the RISC-V SoC. Combines a byte-wide boot-load port with a registered 32-bit instruction fetch port selected by HSEL1. After reset it zero-clears its array, accepts a program byte stream, then serves fetches. Fetches that are misaligned or out of range report a fault instead of returning zero silently.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_word_ram.sv | 46 ++++
 rtl/boot_imem.sv | 183 ++++++++++++++++++
 tb/tb_boot_imem.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the bootloader-fed instruction memory.
//   boot_state_t    : CLEAR (zero sweep) -> LOAD (byte stream) -> RUN (fetch)
//   BYTES_PER_WORD  : bytes in one instruction word
//   lane_enable()   : one-hot byte-enable for a little-endian byte offset
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    BS_CLEAR = 2'd0,
    BS_LOAD  = 2'd1,
    BS_RUN   = 2'd2
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Byte at offset 0 lands in bits [7:0], offset 3 in bits [31:24].
  function automatic logic [BYTES_PER_WORD-1:0] lane_enable(input logic [1:0] byte_offset);
    lane_enable = '0;
    lane_enable[byte_offset] = 1'b1;
  endfunction

endpackage

// File: rtl/imem_word_ram.sv
// -----------------------------------------------------------------------------
// imem_word_ram
// DEPTH_WORDS x 32 storage with one byte-enabled write port and one
// synchronous read port.
//   clk      in   clock
//   wr_be    in   4   per-byte write enable
//   wr_addr  in   AW  word write address
//   wr_data  in   32  write data (lanes selected by wr_be)
//   rd_en    in   1   read strobe; rd_data updates only when set
//   rd_addr  in   AW  word read address
//   rd_data  out  32  registered read data
// -----------------------------------------------------------------------------
module imem_word_ram
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic [BYTES_PER_WORD-1:0] wr_be,
  input  logic [AW-1:0]             wr_addr,
  input  logic [31:0]               wr_data,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [31:0]               rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset; the owner's CLEAR sweep zeroes it, which
  // keeps this mappable onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (wr_be[b]) begin
        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/boot_imem.sv
// -----------------------------------------------------------------------------
// boot_imem
// Bootloader-fed instruction memory. After reset the array is swept to zero
// (CLEAR), then a byte stream is loaded at an auto-incrementing pointer (LOAD),
// then 32-bit little-endian fetches are served with one cycle of latency (RUN).
// Misaligned or out-of-range fetches raise fault instead of returning data.
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-low
//   boot_wr_en    in   boot byte strobe (honoured only in LOAD)
//   boot_wr_data  in   8   boot byte
//   boot_last     in   marks the accepted byte as the final one
//   boot_restart  in   from RUN, go back to CLEAR and reload
//   HSEL1         in   slave select for fetch
//   rd_en_rom     in   fetch request
//   address_rom   in   ADDR_W byte address of the fetch
//   boot_ready    out  high in LOAD
//   run           out  high in RUN
//   boot_ovf      out  sticky: byte offered past the end of the array
//   instruction   out  32  fetched word
//   instr_valid   out  instruction holds a good fetch result
//   fault         out  fetch rejected
// -----------------------------------------------------------------------------
module boot_imem
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_wr_en,
  input  logic [7:0]        boot_wr_data,
  input  logic              boot_last,
  input  logic              boot_restart,
  input  logic              HSEL1,
  input  logic              rd_en_rom,
  input  logic [ADDR_W-1:0] address_rom,
  output logic              boot_ready,
  output logic              run,
  output logic              boot_ovf,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              fault
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / BYTES_PER_WORD;
  localparam int WORD_AW     = $clog2(DEPTH_WORDS);
  // One extra bit so the pointer can rest at DEPTH_BYTES once saturated.
  localparam int PTR_W       = $clog2(DEPTH_BYTES) + 1;

  localparam logic [PTR_W-1:0]   PTR_END        = PTR_W'(DEPTH_BYTES);
  localparam logic [WORD_AW-1:0] CLR_LAST       = WORD_AW'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0]  LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - BYTES_PER_WORD);

  boot_state_t          state, state_next;
  logic [WORD_AW-1:0]   clr_cnt;
  logic [PTR_W-1:0]     byte_ptr;
  logic                 ovf_q;
  logic                 valid_q;
  logic                 fault_q;

  logic                 byte_accept;
  logic                 byte_in_range;
  logic                 clr_done;
  logic                 fetch_req;
  logic                 fetch_ok;

  logic [BYTES_PER_WORD-1:0] ram_be;
  logic [WORD_AW-1:0]        ram_waddr;
  logic [31:0]               ram_wdata;
  logic [31:0]               ram_rd_data;

  assign byte_accept   = (state == BS_LOAD) && boot_wr_en;
  assign byte_in_range = byte_ptr < PTR_END;
  assign clr_done      = (state == BS_CLEAR) && (clr_cnt == CLR_LAST);
  assign fetch_req     = (state == BS_RUN) && HSEL1 && rd_en_rom;
  // Full-width compare: any upper address bit set lands out of range.
  assign fetch_ok      = (address_rom[1:0] == 2'b00) && (address_rom <= LAST_WORD_ADDR);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BS_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_next unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      BS_CLEAR: if (clr_done)                 state_next = BS_LOAD;
      BS_LOAD:  if (byte_accept && boot_last) state_next = BS_RUN;
      BS_RUN:   if (boot_restart)             state_next = BS_CLEAR;
      default:                                state_next = BS_CLEAR;
    endcase
  end

  always_comb begin
    boot_ready = (state == BS_LOAD);
    run        = (state == BS_RUN);
  end

  // ------------------------------------------------ clear sweep and pointer
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_cnt  <= '0;
      byte_ptr <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == BS_CLEAR) begin
        clr_cnt <= clr_done ? '0 : clr_cnt + 1'b1;
      end

      if (clr_done) begin
        byte_ptr <= '0;
      end else if (byte_accept && byte_in_range) begin
        byte_ptr <= byte_ptr + 1'b1;
      end

      if ((state == BS_RUN) && boot_restart) begin
        ovf_q <= 1'b0;
      end else if (byte_accept && !byte_in_range) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign boot_ovf = ovf_q;

  // ----------------------------------------------------- RAM write source
  // CLEAR owns the write port; LOAD writes a single lane per accepted byte.
  always_comb begin
    ram_be    = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (reset) begin
      if (state == BS_CLEAR) begin
        ram_be    = '1;
        ram_waddr = clr_cnt;
      end else if (byte_accept && byte_in_range) begin
        ram_be    = lane_enable(byte_ptr[1:0]);
        ram_waddr = byte_ptr[WORD_AW+1:2];
        ram_wdata = {BYTES_PER_WORD{boot_wr_data}};
      end
    end
  end

  imem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (WORD_AW)
  ) u_ram (
    .clk     (clk),
    .wr_be   (ram_be),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (fetch_req && fetch_ok),
    .rd_addr (address_rom[WORD_AW+1:2]),
    .rd_data (ram_rd_data)
  );

  // ------------------------------------------------------ fetch result
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= fetch_req && fetch_ok;
      fault_q <= fetch_req && !fetch_ok;
    end
  end

  // The RAM output register is the fetch data register; masking it keeps
  // instruction at zero on faults, idle cycles and in reset.
  assign instruction = valid_q ? ram_rd_data : 32'h0;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_boot_imem.sv
// -----------------------------------------------------------------------------
// tb_boot_imem
// Directed bench for boot_imem. Instance a uses DEPTH_BYTES=64, instance b
// uses DEPTH_BYTES=16 for the overflow scenario. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_boot_imem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_wr_en, a_last, a_restart, a_hsel, a_rd_en;
  logic [7:0]  a_wr_data;
  logic [31:0] a_addr;
  logic        a_ready, a_run, a_ovf, a_valid, a_fault;
  logic [31:0] a_instr;

  logic        b_wr_en, b_last, b_restart, b_hsel, b_rd_en;
  logic [7:0]  b_wr_data;
  logic [31:0] b_addr;
  logic        b_ready, b_run, b_ovf, b_valid, b_fault;
  logic [31:0] b_instr;

  int n_tests = 0;
  int n_fail  = 0;

  boot_imem #(.DEPTH_BYTES(64), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .boot_wr_en(a_wr_en), .boot_wr_data(a_wr_data), .boot_last(a_last),
    .boot_restart(a_restart), .HSEL1(a_hsel), .rd_en_rom(a_rd_en),
    .address_rom(a_addr), .boot_ready(a_ready), .run(a_run),
    .boot_ovf(a_ovf), .instruction(a_instr), .instr_valid(a_valid),
    .fault(a_fault)
  );

  boot_imem #(.DEPTH_BYTES(16), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .boot_wr_en(b_wr_en), .boot_wr_data(b_wr_data), .boot_last(b_last),
    .boot_restart(b_restart), .HSEL1(b_hsel), .rd_en_rom(b_rd_en),
    .address_rom(b_addr), .boot_ready(b_ready), .run(b_run),
    .boot_ovf(b_ovf), .instruction(b_instr), .instr_valid(b_valid),
    .fault(b_fault)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] d, input logic last);
    a_wr_en = 1'b1; a_wr_data = d; a_last = last;
    step();
    a_wr_en = 1'b0; a_last = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic last);
    b_wr_en = 1'b1; b_wr_data = d; b_last = last;
    step();
    b_wr_en = 1'b0; b_last = 1'b0;
  endtask

  task automatic a_fetch(input logic [31:0] ad, input logic sel);
    a_hsel = sel; a_rd_en = 1'b1; a_addr = ad;
    step();
    a_hsel = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic b_fetch(input logic [31:0] ad);
    b_hsel = 1'b1; b_rd_en = 1'b1; b_addr = ad;
    step();
    b_hsel = 1'b0; b_rd_en = 1'b0;
  endtask

  // Edges until a.boot_ready rises; -1 if it never does within the budget.
  task automatic a_edges_to_ready(output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (a_ready) begin
        n = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    int na, nb;
    reset = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({a_ready, a_run, a_ovf, a_valid, a_fault, a_instr} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: rdy=%b run=%b ovf=%b v=%b f=%b instr=%h, expected all 0",
               a_ready, a_run, a_ovf, a_valid, a_fault, a_instr);
    end
    n_tests++;
    if ({b_ready, b_run, b_ovf, b_valid, b_fault, b_instr} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: rdy=%b run=%b ovf=%b v=%b f=%b instr=%h, expected all 0",
               b_ready, b_run, b_ovf, b_valid, b_fault, b_instr);
    end
    reset = 1'b1;
    na = -1; nb = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (b_ready && nb < 0) nb = k;
      if (a_ready) begin
        na = k;
        break;
      end
    end
    n_tests++;
    if (na != 16) begin
      n_fail++;
      $display("FAIL clear_len_64: boot_ready after %0d edges, expected 16", na);
    end
    n_tests++;
    if (nb != 4) begin
      n_fail++;
      $display("FAIL clear_len_16: boot_ready after %0d edges, expected 4", nb);
    end
  endtask

  task automatic test_load_fetch();
    a_send(8'h13, 1'b0); a_send(8'h00, 1'b0); a_send(8'h00, 1'b0); a_send(8'h00, 1'b0);
    a_send(8'h93, 1'b0); a_send(8'h00, 1'b0); a_send(8'h10, 1'b0);
    n_tests++;
    if ({a_run, a_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL load_before_last: run=%b rdy=%b, expected run=0 rdy=1", a_run, a_ready);
    end
    a_send(8'h00, 1'b1);
    n_tests++;
    if ({a_run, a_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_after_last: run=%b rdy=%b, expected run=1 rdy=0", a_run, a_ready);
    end
    a_fetch(32'h0, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0000_0013, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_0x0: instr=%h v=%b f=%b, expected 00000013 v=1 f=0", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h4, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0010_0093, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_0x4: instr=%h v=%b f=%b, expected 00100093 v=1 f=0", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h8, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_unwritten: instr=%h v=%b f=%b, expected 00000000 v=1 f=0", a_instr, a_valid, a_fault);
    end
    step();
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== 34'h0) begin
      n_fail++;
      $display("FAIL fetch_pulse: instr=%h v=%b f=%b, expected all 0 on idle cycle", a_instr, a_valid, a_fault);
    end
  endtask

  task automatic test_back_to_back();
    a_hsel = 1'b1; a_rd_en = 1'b1; a_addr = 32'h4;
    step();
    n_tests++;
    if ({a_instr, a_valid} !== {32'h0010_0093, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_first: instr=%h v=%b, expected 00100093 v=1", a_instr, a_valid);
    end
    a_addr = 32'h0;
    step();
    n_tests++;
    if ({a_instr, a_valid} !== {32'h0000_0013, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second: instr=%h v=%b, expected 00000013 v=1", a_instr, a_valid);
    end
    a_hsel = 1'b0; a_rd_en = 1'b0;
    step();
  endtask

  task automatic test_faults();
    a_fetch(32'h2, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL misaligned: instr=%h v=%b f=%b, expected 00000000 v=0 f=1", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h40, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL out_of_range_0x40: instr=%h v=%b f=%b, expected 00000000 v=0 f=1", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h3C, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL last_word_0x3c: instr=%h v=%b f=%b, expected 00000000 v=1 f=0", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h0, 1'b0);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== 34'h0) begin
      n_fail++;
      $display("FAIL hsel_low: instr=%h v=%b f=%b, expected all 0", a_instr, a_valid, a_fault);
    end
    a_fetch(32'h8000_0000, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_fault} !== {32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL upper_addr_bits: instr=%h v=%b f=%b, expected 00000000 v=0 f=1", a_instr, a_valid, a_fault);
    end
    // A boot byte offered in RUN must not land in the array.
    a_send(8'hFF, 1'b1);
    a_fetch(32'h8, 1'b1);
    n_tests++;
    if ({a_instr, a_valid, a_run} !== {32'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_in_run_ignored: instr=%h v=%b run=%b, expected 00000000 v=1 run=1", a_instr, a_valid, a_run);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) begin
      b_send(8'h10 + 8'(i), i == 17);
      if (i == 15) begin
        n_tests++;
        if (b_ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_at_16: ovf=%b, expected 0", b_ovf);
        end
      end
      if (i == 16) begin
        n_tests++;
        if ({b_ovf, b_run} !== 2'b10) begin
          n_fail++;
          $display("FAIL ovf_at_17: ovf=%b run=%b, expected ovf=1 run=0", b_ovf, b_run);
        end
      end
    end
    n_tests++;
    if ({b_ovf, b_run, b_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL ovf_last: ovf=%b run=%b rdy=%b, expected ovf=1 run=1 rdy=0", b_ovf, b_run, b_ready);
    end
    b_fetch(32'h0);
    n_tests++;
    if ({b_instr, b_valid} !== {32'h1312_1110, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_word0: instr=%h v=%b, expected 13121110 v=1", b_instr, b_valid);
    end
    b_fetch(32'hC);
    n_tests++;
    if ({b_instr, b_valid} !== {32'h1F1E_1D1C, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_word3: instr=%h v=%b, expected 1f1e1d1c v=1", b_instr, b_valid);
    end
    b_fetch(32'h10);
    n_tests++;
    if ({b_valid, b_fault} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_range_0x10: v=%b f=%b, expected v=0 f=1", b_valid, b_fault);
    end
    b_restart = 1'b1;
    step();
    b_restart = 1'b0;
    n_tests++;
    if ({b_ovf, b_run} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovf_cleared: ovf=%b run=%b, expected 0 0 after restart", b_ovf, b_run);
    end
  endtask

  task automatic test_restart();
    int n;
    a_restart = 1'b1; a_hsel = 1'b1; a_rd_en = 1'b1; a_addr = 32'h0;
    step();
    a_restart = 1'b0; a_hsel = 1'b0; a_rd_en = 1'b0;
    n_tests++;
    if ({a_instr, a_valid, a_fault, a_run} !== {32'h0000_0013, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_fetch: instr=%h v=%b f=%b run=%b, expected 00000013 v=1 f=0 run=0",
               a_instr, a_valid, a_fault, a_run);
    end
    a_edges_to_ready(n);
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL restart_clear_len: boot_ready after %0d edges, expected 16", n);
    end
    a_send(8'hAA, 1'b0); a_send(8'hBB, 1'b0); a_send(8'hCC, 1'b0); a_send(8'hDD, 1'b1);
    a_fetch(32'h0, 1'b1);
    n_tests++;
    if ({a_instr, a_valid} !== {32'hDDCC_BBAA, 1'b1}) begin
      n_fail++;
      $display("FAIL reload_word0: instr=%h v=%b, expected ddccbbaa v=1", a_instr, a_valid);
    end
    a_fetch(32'h4, 1'b1);
    n_tests++;
    if ({a_instr, a_valid} !== {32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reload_cleared_word1: instr=%h v=%b, expected 00000000 v=1", a_instr, a_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    a_restart = 1'b1;
    step();
    a_restart = 1'b0;
    a_edges_to_ready(n);
    for (int i = 1; i <= 5; i++) a_send(8'(i), 1'b0);
    reset = 1'b0;
    a_wr_en = 1'b1; a_wr_data = 8'h77; a_hsel = 1'b1; a_rd_en = 1'b1; a_addr = 32'h0;
    step();
    a_wr_en = 1'b0; a_hsel = 1'b0; a_rd_en = 1'b0;
    n_tests++;
    if ({a_ready, a_run, a_ovf, a_valid, a_fault, a_instr} !== 37'h0) begin
      n_fail++;
      $display("FAIL midload_reset: rdy=%b run=%b ovf=%b v=%b f=%b instr=%h, expected all 0",
               a_ready, a_run, a_ovf, a_valid, a_fault, a_instr);
    end
    reset = 1'b1;
    a_edges_to_ready(n);
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL midload_clear_len: boot_ready after %0d edges, expected 16", n);
    end
    a_send(8'h11, 1'b0); a_send(8'h22, 1'b0); a_send(8'h33, 1'b0); a_send(8'h44, 1'b1);
    a_fetch(32'h0, 1'b1);
    n_tests++;
    if ({a_instr, a_valid} !== {32'h4433_2211, 1'b1}) begin
      n_fail++;
      $display("FAIL midload_ptr_restart: instr=%h v=%b, expected 44332211 v=1", a_instr, a_valid);
    end
    a_fetch(32'h4, 1'b1);
    n_tests++;
    if ({a_instr, a_valid} !== {32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL midload_word1_cleared: instr=%h v=%b, expected 00000000 v=1", a_instr, a_valid);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_wr_en = 1'b0; a_last = 1'b0; a_restart = 1'b0; a_hsel = 1'b0; a_rd_en = 1'b0;
    a_wr_data = 8'h0; a_addr = 32'h0;
    b_wr_en = 1'b0; b_last = 1'b0; b_restart = 1'b0; b_hsel = 1'b0; b_rd_en = 1'b0;
    b_wr_data = 8'h0; b_addr = 32'h0;

    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_faults();
    test_overflow();
    test_restart();
    test_reset_mid_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
